bpsk_frame_rx: RTL and testbench

- Receive-side deframer for the BPSK link.
- Consumes hard-decision bits from the demodulator bit slicer, one strobe per symbol.
- Hunts for the 64-bit magic sync word, then collects 16 x 32-bit data words and a 32-bit XOR checksum, and verifies the checksum.
- Presents the frame to the host through a level interrupt / acknowledge handshake; this is the counterpart of the transmit framer.

---
 rtl/bpsk_pkg.sv | 26 ++
 rtl/bpsk_sync_detect.sv | 47 ++++
 rtl/bpsk_frame_rx.sv | 147 ++++++++++++++
 tb/tb_bpsk_frame_rx.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bpsk_pkg.sv
// ============================================================================
// Module      : bpsk_pkg
// Description : Shared BPSK link constants, rx state encoding and word type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bpsk_pkg;

  localparam logic [63:0] MAGIC_PATTERN   = 64'hB5A6FFFF9BE37C39;
  localparam int          WORD_CNT        = 16;
  localparam int          WORD_BITS       = 32;
  localparam int          FRAME_DATA_BITS = WORD_CNT * WORD_BITS;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    DATA = 2'd1,
    CSUM = 2'd2,
    HOLD = 2'd3
  } rx_state_t;

  typedef logic [WORD_BITS-1:0] frame_word_t;

endpackage

`default_nettype wire

// File: rtl/bpsk_sync_detect.sv
// ============================================================================
// Module      : bpsk_sync_detect
// Description : Sliding sync-word window with true/inverted comparators.
//               Inverted match only with BPSK_RX_POLARITY_AUTO_EN defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bpsk_sync_detect
  import bpsk_pkg::*;
(
  input  logic Clk,
  input  logic Reset_n,
  input  logic Shift,
  input  logic BitIn,
  input  logic Clear,
  output logic SyncHit,
  output logic SyncInv
);

  // Only 63 history bits are stored; the current bit completes the window.
  logic [62:0] r_syncSr;
  logic [63:0] w_window;

  assign w_window = {r_syncSr, BitIn};

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_syncSr <= '0;
    end else if (Clear) begin
      r_syncSr <= '0;
    end else if (Shift) begin
      r_syncSr <= w_window[62:0];
    end
  end

  assign SyncHit = Shift && (w_window == MAGIC_PATTERN);

`ifdef BPSK_RX_POLARITY_AUTO_EN
  assign SyncInv = Shift && !SyncHit && (w_window == ~MAGIC_PATTERN);
`else
  assign SyncInv = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/bpsk_frame_rx.sv
// ============================================================================
// Module      : bpsk_frame_rx
// Description : BPSK receive deframer: sync hunt, 16-word capture, XOR
//               checksum, interrupt/ack handshake. Optional auto-polarity
//               recovery under BPSK_RX_POLARITY_AUTO_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bpsk_frame_rx
  import bpsk_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        BitIn,
  input  logic        BitStb,
  input  logic        CarrierLock,
  input  logic        Ack,
  output frame_word_t Data [0:WORD_CNT-1],
  output logic        Int,
  output logic        ChkErr,
  output logic        Inverted,
  output logic [7:0]  Aborts
);

  localparam logic [8:0] c_lastDataBit = 9'(FRAME_DATA_BITS - 1);

  rx_state_t   r_state;
  logic [8:0]  r_bitCnt;
  frame_word_t r_wordSr;
  frame_word_t r_runXor;

  logic        w_pol;
  logic        w_bit;
  frame_word_t w_word;
  logic        w_syncHit;
  logic        w_syncInv;
  logic        w_shift;
  logic        w_enterData;
  logic        w_abort;
  logic        w_holdAck;
  logic        w_frameDone;

  assign w_shift     = (r_state == HUNT) && BitStb;
  assign w_enterData = w_syncHit || w_syncInv;
  assign w_abort     = ((r_state == DATA) || (r_state == CSUM)) && !CarrierLock;
  assign w_holdAck   = (r_state == HOLD) && Ack;
  assign w_frameDone = (r_state == CSUM) && CarrierLock && BitStb && (r_bitCnt[4:0] == 5'd31);
  assign w_bit       = BitIn ^ w_pol;
  assign w_word      = {r_wordSr[WORD_BITS-2:0], w_bit};

  bpsk_sync_detect u_syncDetect (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .Shift   (w_shift),
    .BitIn   (BitIn),
    .Clear   (w_abort || w_holdAck),
    .SyncHit (w_syncHit),
    .SyncInv (w_syncInv)
  );

`ifdef BPSK_RX_POLARITY_AUTO_EN
  logic r_pol;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_pol    <= 1'b0;
      Inverted <= 1'b0;
    end else begin
      if (w_enterData) r_pol <= !w_syncHit;
      if (w_frameDone) Inverted <= r_pol;
    end
  end

  assign w_pol = r_pol;
`else
  assign w_pol    = 1'b0;
  assign Inverted = 1'b0;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state  <= HUNT;
      r_bitCnt <= '0;
      r_wordSr <= '0;
      r_runXor <= '0;
      for (int i = 0; i < WORD_CNT; i++) Data[i] <= '0;
      Int      <= 1'b0;
      ChkErr   <= 1'b0;
      Aborts   <= '0;
    end else begin
      case (r_state)
        HUNT: begin
          if (w_enterData) begin
            r_state  <= DATA;
            r_bitCnt <= '0;
            r_runXor <= '0;
          end
        end
        DATA: begin
          if (w_abort) begin
            r_state <= HUNT;
            if (Aborts != 8'hFF) Aborts <= Aborts + 8'd1;
          end else if (BitStb) begin
            r_wordSr <= w_word;
            if (r_bitCnt[4:0] == 5'd31) begin
              Data[r_bitCnt[8:5]] <= w_word;
              r_runXor            <= r_runXor ^ w_word;
            end
            if (r_bitCnt == c_lastDataBit) begin
              r_state  <= CSUM;
              r_bitCnt <= '0;
            end else begin
              r_bitCnt <= r_bitCnt + 9'd1;
            end
          end
        end
        CSUM: begin
          if (w_abort) begin
            r_state <= HUNT;
            if (Aborts != 8'hFF) Aborts <= Aborts + 8'd1;
          end else if (w_frameDone) begin
            r_wordSr <= w_word;
            ChkErr   <= (w_word != r_runXor);
            Int      <= 1'b1;
            r_state  <= HOLD;
            r_bitCnt <= '0;
          end else if (BitStb) begin
            r_wordSr <= w_word;
            r_bitCnt <= r_bitCnt + 9'd1;
          end
        end
        HOLD: begin
          // Strobes here are dropped; only the host ack moves us on.
          if (Ack) begin
            Int     <= 1'b0;
            r_state <= HUNT;
          end
        end
        default: r_state <= HUNT;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bpsk_frame_rx.sv
// ============================================================================
// Module      : tb_bpsk_frame_rx
// Description : Directed self-checking bench for bpsk_frame_rx with a
//               frame-level reference model compared every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bpsk_frame_rx;
  import bpsk_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        BitIn = 1'b0;
  logic        BitStb = 1'b0;
  logic        CarrierLock = 1'b0;
  logic        Ack = 1'b0;
  logic [31:0] Data [0:15];
  logic        Int;
  logic        ChkErr;
  logic        Inverted;
  logic [7:0]  Aborts;

  int checks = 0;
  int errors = 0;
  bit cmpOn  = 1'b0;

  always #5 Clk = ~Clk;

  bpsk_frame_rx dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .BitIn       (BitIn),
    .BitStb      (BitStb),
    .CarrierLock (CarrierLock),
    .Ack         (Ack),
    .Data        (Data),
    .Int         (Int),
    .ChkErr      (ChkErr),
    .Inverted    (Inverted),
    .Aborts      (Aborts)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Frame-level model: collect the raw stream, decide at frame end.
  int          mMode;     // 0 hunting, 1 collecting, 2 presenting
  logic [63:0] mHist;
  logic        mPol;
  bit          mBits[$];
  logic [31:0] eData [0:15];
  logic        eInt, eChk, eInv;
  int          eAborts;

  task automatic finishFrame();
    logic [31:0] w [0:16];
    logic [31:0] x;
    x = '0;
    for (int k = 0; k < 17; k++) begin
      w[k] = '0;
      for (int j = 0; j < 32; j++) w[k] = {w[k][30:0], mBits[k*32+j]};
    end
    for (int k = 0; k < 16; k++) x = x ^ w[k];
    for (int k = 0; k < 16; k++) eData[k] = w[k];
    eChk  = (w[16] != x);
    eInv  = mPol;
    eInt  = 1'b1;
    mMode = 2;
  endtask

  task automatic modelEdge(input logic stb, input logic b, input logic lock, input logic ack);
    if (mMode == 0) begin
      if (stb) begin
        mHist = {mHist[62:0], b};
        if (mHist == MAGIC_PATTERN) begin
          mMode = 1; mPol = 1'b0; mBits.delete();
        end
`ifdef BPSK_RX_POLARITY_AUTO_EN
        else if (mHist == ~MAGIC_PATTERN) begin
          mMode = 1; mPol = 1'b1; mBits.delete();
        end
`endif
      end
    end else if (mMode == 1) begin
      if (!lock) begin
        mMode = 0; mHist = '0;
        if (eAborts < 255) eAborts++;
      end else if (stb) begin
        mBits.push_back(b ^ mPol);
        if (mBits.size() == 544) finishFrame();
      end
    end else begin
      if (ack) begin
        eInt = 1'b0; mMode = 0; mHist = '0;
      end
    end
  endtask

  always @(negedge Clk) begin
    if (cmpOn) begin
      check("Int", {31'b0, Int}, {31'b0, eInt});
      check("ChkErr", {31'b0, ChkErr}, {31'b0, eChk});
      check("Inverted", {31'b0, Inverted}, {31'b0, eInv});
      check("Aborts", {24'b0, Aborts}, 32'(eAborts));
      if (eInt) begin
        for (int k = 0; k < 16; k++) check($sformatf("Data[%0d]", k), Data[k], eData[k]);
      end
    end
  end

  task automatic cyc(input logic stb, input logic b, input logic lock, input logic ack);
    BitStb = stb; BitIn = b; CarrierLock = lock; Ack = ack;
    @(posedge Clk);
    modelEdge(stb, b, lock, ack);
    #1;
  endtask

  bit txQ[$];

  task automatic pushBits(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) txQ.push_back(v[i]);
  endtask

  task automatic buildFrame(input logic [31:0] base, input logic [31:0] csum,
                            input bit inv, input bit badMagic);
    logic [63:0] m;
    int start;
    txQ.delete();
    for (int i = 0; i < 20; i++) txQ.push_back(1'($urandom_range(0, 1)));
    m = MAGIC_PATTERN;
    if (badMagic) m[0] = ~m[0];
    start = txQ.size();
    pushBits(m, 64);
    for (int i = 0; i < 16; i++) pushBits({32'h0, base + 32'(i)}, 32);
    pushBits({32'h0, csum}, 32);
    if (inv) for (int i = start; i < txQ.size(); i++) txQ[i] = !txQ[i];
  endtask

  task automatic sendRange(input int first, input int last, input int gap,
                           input logic lock, input logic ack);
    for (int i = first; i <= last; i++) begin
      cyc(1'b1, txQ[i], lock, ack);
      repeat (gap) cyc(1'b0, 1'b0, lock, ack);
    end
  endtask

  // Whole frame; Int must be low before the last strobe and high right after.
  task automatic sendFrameCheck(input int gap, input logic ack);
    sendRange(0, txQ.size() - 2, gap, 1'b1, ack);
    check("int_before_last", {31'b0, Int}, 32'h0);
    cyc(1'b1, txQ[txQ.size() - 1], 1'b1, ack);
    check("int_after_last", {31'b0, Int}, 32'h1);
  endtask

  task automatic ackPulse(input logic stb);
    cyc(stb, 1'b1, 1'b1, 1'b1);
    check("int_after_ack", {31'b0, Int}, 32'h0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    mMode = 0; mHist = '0; mPol = 1'b0;
    eInt = 1'b0; eChk = 1'b0; eInv = 1'b0; eAborts = 0;
    for (int k = 0; k < 16; k++) eData[k] = '0;

    repeat (2) @(posedge Clk);
    #1;
    check("rst_int", {31'b0, Int}, 32'h0);
    check("rst_chkerr", {31'b0, ChkErr}, 32'h0);
    check("rst_inverted", {31'b0, Inverted}, 32'h0);
    check("rst_aborts", {24'b0, Aborts}, 32'h0);
    check("rst_data0", Data[0], 32'h0);
    check("rst_data15", Data[15], 32'h0);
    Reset_n = 1'b1; CarrierLock = 1'b1;
    cmpOn = 1'b1;

    // Clean frame, strobe on every other cycle
    buildFrame(32'h1000_0000, 32'h0000_0000, 1'b0, 1'b0);
    sendFrameCheck(1, 1'b0);
    check("clean_data0", Data[0], 32'h1000_0000);
    check("clean_data15", Data[15], 32'h1000_000F);
    check("clean_chkerr", {31'b0, ChkErr}, 32'h0);
    check("clean_inverted", {31'b0, Inverted}, 32'h0);
    ackPulse(1'b0);

    // Checksum fault
    buildFrame(32'h1000_0000, 32'h0000_0001, 1'b0, 1'b0);
    sendFrameCheck(0, 1'b0);
    check("csum_chkerr", {31'b0, ChkErr}, 32'h1);
    check("csum_data7", Data[7], 32'h1000_0007);
    ackPulse(1'b1);

    // Handshake: second frame arrives while still unacknowledged
    buildFrame(32'h4000_0000, 32'h0, 1'b0, 1'b0);
    sendFrameCheck(0, 1'b0);
    buildFrame(32'h5000_0000, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 2000; i++) cyc(1'b1, (i < txQ.size()) ? txQ[i] : 1'b0, 1'b1, 1'b0);
    check("hold_int", {31'b0, Int}, 32'h1);
    check("hold_data0", Data[0], 32'h4000_0000);
    ackPulse(1'b0);
    sendFrameCheck(0, 1'b0);
    check("hs_data0", Data[0], 32'h5000_0000);
    ackPulse(1'b0);

    // Ack held high throughout does not suppress the interrupt
    buildFrame(32'h6000_0000, 32'h0, 1'b0, 1'b0);
    sendFrameCheck(0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    check("ackheld_int_drop", {31'b0, Int}, 32'h0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);

    // Lock loss at data bit 200
    buildFrame(32'h7000_0000, 32'h0, 1'b0, 1'b0);
    sendRange(0, 20 + 64 + 199, 0, 1'b1, 1'b0);
    cyc(1'b1, txQ[20 + 64 + 200], 1'b0, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("lock_aborts", {24'b0, Aborts}, 32'h1);
    check("lock_int", {31'b0, Int}, 32'h0);
    buildFrame(32'h1000_0000, 32'h0, 1'b0, 1'b0);
    sendFrameCheck(0, 1'b0);
    check("lock_next_data3", Data[3], 32'h1000_0003);
    ackPulse(1'b0);

    // Lock loss on the strobe that would complete the frame
    buildFrame(32'h8000_0000, 32'h0, 1'b0, 1'b0);
    sendRange(0, txQ.size() - 2, 0, 1'b1, 1'b0);
    cyc(1'b1, txQ[txQ.size() - 1], 1'b0, 1'b0);
    check("lastbit_abort_int", {31'b0, Int}, 32'h0);
    check("lastbit_abort_cnt", {24'b0, Aborts}, 32'h2);
    repeat (2) cyc(1'b0, 1'b0, 1'b1, 1'b0);

    // False sync: magic with bit 0 flipped, then a valid frame
    buildFrame(32'h2000_0000, 32'h0, 1'b0, 1'b1);
    sendRange(0, 20 + 64 + 99, 0, 1'b1, 1'b0);
    check("false_sync_int", {31'b0, Int}, 32'h0);
    buildFrame(32'h3000_0000, 32'h0, 1'b0, 1'b0);
    sendFrameCheck(0, 1'b0);
    check("false_sync_data0", Data[0], 32'h3000_0000);
    ackPulse(1'b0);

    // Fully inverted frame
    buildFrame(32'h1000_0000, 32'h0, 1'b1, 1'b0);
`ifdef BPSK_RX_POLARITY_AUTO_EN
    sendFrameCheck(0, 1'b0);
    check("pol_inverted", {31'b0, Inverted}, 32'h1);
    check("pol_chkerr", {31'b0, ChkErr}, 32'h0);
    check("pol_data3", Data[3], 32'h1000_0003);
    ackPulse(1'b0);
`else
    sendRange(0, txQ.size() - 1, 0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("pol_no_int", {31'b0, Int}, 32'h0);
`endif

    repeat (3) cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cmpOn = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
